// File: rtl/inst_mem_dumper_pkg.sv
// Shared debug-unit definitions for the instruction-memory dumper.
// Holds the FSM state encoding, word/byte geometry and the byte-stream handshake rule.
// Pure declarations; no logic of its own.
package inst_mem_dumper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_FIN
  } state_t;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  // Word index to byte address: one word is four bytes.
  localparam int WORD_SHIFT     = 2;

  // A byte moves on a rising edge where the source offers it and the sink takes it.
  function automatic logic byte_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/inst_mem_dumper_word_serializer.sv
// Word serializer: holds one fetched word and offers it as bytes, MSB first.
// Latency: first byte valid the cycle after load; one byte per accepted handshake.
// Backpressure: tx_valid/tx_data hold steady while tx_ready is low; nothing is dropped.
module inst_mem_dumper_word_serializer
  import inst_mem_dumper_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              last
);

  logic [DATA_W-1:0] word;
  logic [1:0]        byte_sel;
  logic              valid;

  // Load a fresh word, then step the byte pointer down on each accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      word     <= '0;
      byte_sel <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      word     <= word_in;
      byte_sel <= 2'(BYTES_PER_WORD - 1);
      valid    <= 1'b1;
    end else if (byte_fire(valid, tx_ready)) begin
      if (byte_sel == 2'd0) begin
        valid <= 1'b0;
      end else begin
        byte_sel <= byte_sel - 2'd1;
      end
    end
  end

  assign tx_data  = word[BYTE_W*byte_sel +: BYTE_W];
  assign tx_valid = valid;
  assign last     = (byte_sel == 2'd0);

endmodule

// File: rtl/inst_mem_dumper.sv
// Instruction-memory dumper: reads words from address 0 upward and streams them as bytes.
// Latency: start to first tx_valid 3 cycles; 6 cycles per word with tx_ready held high.
// Backpressure: tx_ready low stalls the SEND state; no new read is issued until the word drains.
module inst_mem_dumper
  import inst_mem_dumper_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_WORDS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_inc;
  logic [CNT_W-1:0] cnt_req;
  logic             more_words;
  logic             load;
  logic             last;
  logic             fire;

  // Requests beyond the memory depth are clamped so the address never passes the top word.
  assign cnt_req    = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign idx_inc    = idx + 1'b1;
  assign more_words = (idx_inc < cnt);
  assign fire       = byte_fire(tx_valid, tx_ready);

  // The address follows the word index, so it holds the last issued address between reads.
  assign mem_rd_addr = ADDR_W'(idx) << WORD_SHIFT;

  // State register plus the word count and word index captured/advanced by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        cnt <= cnt_req;
        idx <= '0;
      end else if (state == ST_SEND && fire && last && more_words) begin
        idx <= idx_inc;
      end
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (cnt_req == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        load      = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy = 1'b1;
        if (fire && last) begin
          state_nxt = more_words ? ST_READ : ST_FIN;
        end
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  inst_mem_dumper_word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .word_in  (mem_rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .last     (last)
  );

endmodule
